fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//   Write-side pointer and full-flag logic of the async FIFO, all in the wclk domain.
//   Sits upstream of the FIFO memory and the read-pointer block.
//   Accepts write requests and produces the memory write address.
//   Publishes a Gray-coded write pointer for the read domain to synchronize.
//   Uses the already-synchronized Gray read pointer to derive full, occupancy and overflow status.
// PARAMETERS
//   addr_width  4  pointer width incl. wrap bit; FIFO depth = 2**(addr_width-1)
//   AF_MARGIN   2  almost-full margin in entries (used only with FIFO_ALMOST_FULL_EN)
// PORTS
//   wclk         in   1             write clock
//   wrst         in   1             synchronous active-low reset (sampled on posedge wclk)
//   winc         in   1             write request
//   raddr_g      in   addr_width    Gray read pointer, already 2-flop synced into wclk
//   wfull        out  1             FIFO full; write not accepted while high
//   waddress     out  addr_width-1  memory write address = waddr[addr_width-2:0]
//   waddr_g      out  addr_width    registered Gray code of waddr, to the read domain
//   wcount       out  addr_width    occupancy seen by the writer, 0..depth
//   woverflow    out  1             sticky: a write was attempted while full
//   wafull       out  1             almost-full (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all registers update only on posedge wclk.
//     While wrst==0: waddr=0, rbin=0, waddr_g=0, woverflow=0.
//     Consequently wfull=0, wcount=0, wafull=0, waddress=0.
//   - Gray->binary of raddr_g is generic: rbin[i] = ^raddr_g[addr_width-1:i].
//     It is registered, so 1 wclk of latency from raddr_g to rbin. No lookup table.
//   - Binary->Gray: waddr_g <= waddr ^ (waddr>>1), registered every cycle.
//     waddr_g therefore lags waddr by 1 wclk.
//     Only one bit changes per increment, including on wrap.
//   - wfull = (waddr[MSB] != rbin[MSB]) && (waddr[MSB-1:0] == rbin[MSB-1:0]). Combinational.
//   - Accept = winc && !wfull. On accept: waddr <= waddr+1 (mod 2**addr_width).
//     Memory write strobe = accept; the data/address pair is waddress in the same cycle.
//   - winc && wfull: waddr holds, woverflow <= 1. woverflow clears only on reset.
//   - wcount = waddr - rbin, modulo 2**addr_width. Combinational; never exceeds depth.
//   - Wrap: waddr 2**addr_width-1 -> 0 on accept. The MSB toggles, waddress wraps to 0.
//     Full/empty detection stays correct across the wrap.
//   - Simultaneous: a read that advances rbin in the same cycle as a write at full does not
//     help that write. wfull is evaluated on the current rbin, so the write is rejected.
//     The freed space is visible from the next cycle.
//   - Pessimism: wfull may stay high up to 3 wclk after the reader frees space
//     (2 sync + 1 convert). It never deasserts early.
//   - Reset mid-operation: pointers return to 0 on the next posedge.
//     The read side must be reset at the same time; mismatched resets are unsupported.
// CONFIGURATION
//   FIFO_ALMOST_FULL_EN defined:
//     wafull = (wcount >= depth - AF_MARGIN), combinational.
//     Requires 0 < AF_MARGIN < depth.
//   FIFO_ALMOST_FULL_EN undefined:
//     wafull tied to 0 and no compare logic is built.
//     All other behaviour is identical.
// TESTING
//   1. Hold wrst=0 for 2 wclk, then release.
//      -> waddr_g=0, wfull=0, wcount=0, woverflow=0.
//   2. winc=1 for 8 cycles, raddr_g=0.
//      -> waddress steps 0..7; wfull=1 after the 8th write; wcount=8.
//      -> waddr_g sequence 0,1,3,2,6,7,5,4,C.
//   3. Full, then winc=1 for 1 more cycle.
//      -> waddr stays 8, woverflow=1 and stays 1 until reset.
//   4. Full with waddr=8, drive raddr_g=4'b0001 (rbin=1).
//      -> wfull falls 1 cycle later, wcount=7, the next write is accepted.
//   5. Cycle 20 writes with a modelled reader following.
//      -> waddr wraps F->0; Hamming distance of consecutive waddr_g values <= 1.
//      -> No false wfull.
//   6. With FIFO_ALMOST_FULL_EN and AF_MARGIN=2, write 6 entries with rbin=0.
//      -> wafull=1 at wcount=6, 0 at wcount=5.
//      Without the macro, wafull stays 0 throughout.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, Gray publication and full/occupancy/overflow status of the async FIFO (wclk domain).
// Optional almost-full flag is built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full #(
    parameter int unsigned addr_width = 4,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [addr_width-1:0] raddr_g,
    output logic                  wfull,
    output logic [addr_width-2:0] waddress,
    output logic [addr_width-1:0] waddr_g,
    output logic [addr_width-1:0] wcount,
    output logic                  woverflow,
    output logic                  wafull
);

    localparam int unsigned MSB   = addr_width - 1;
    localparam int unsigned DEPTH = 2 ** (addr_width - 1);

    logic [MSB:0] waddr;
    logic [MSB:0] rbin;
    logic [MSB:0] rbin_c;
    logic         accept;

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits
    always_comb begin
        rbin_c = '0;
        for (int i = 0; i < int'(addr_width); i++) begin
            rbin_c[i] = ^(raddr_g >> i);
        end
    end

    // Full when pointers differ only in the wrap bit
    assign wfull    = (waddr[MSB] != rbin[MSB]) && (waddr[MSB-1:0] == rbin[MSB-1:0]);
    assign accept   = winc && !wfull;
    assign wcount   = waddr - rbin;
    assign waddress = waddr[MSB-1:0];

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            waddr     <= '0;
            rbin      <= '0;
            waddr_g   <= '0;
            woverflow <= 1'b0;
        end else begin
            rbin    <= rbin_c;
            waddr_g <= waddr ^ (waddr >> 1);
            if (accept) begin
                waddr <= waddr + addr_width'(1);
            end
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    assign wafull = (wcount >= addr_width'(DEPTH - AF_MARGIN));
`else
    assign wafull = 1'b0;
    // Margin only matters when the almost-full compare is built
    if (AF_MARGIN >= DEPTH) begin : g_af_margin_unused
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: table-based Gray model plus an accepted-write address scoreboard.
// Expects wafull behaviour according to FIFO_ALMOST_FULL_EN.
module tb_fifo_wptr_full;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFM   = 2;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic [AW-1:0] raddr_g;
    logic          wfull;
    logic [AW-2:0] waddress;
    logic [AW-1:0] waddr_g;
    logic [AW-1:0] wcount;
    logic          woverflow;
    logic          wafull;

    always #5 wclk = ~wclk;

    fifo_wptr_full #(.addr_width(AW), .AF_MARGIN(AFM)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .raddr_g(raddr_g),
        .wfull(wfull), .waddress(waddress), .waddr_g(waddr_g),
        .wcount(wcount), .woverflow(woverflow), .wafull(wafull)
    );

    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] gray_exp [9]  = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    int checks = 0;
    int errors = 0;

    logic [3:0] m_waddr, m_rbin, m_gray;
    logic       m_ovf;
    logic [2:0] exp_q [$];
    logic [3:0] gq [$];
    logic [3:0] prev_g;
    logic [3:0] rd;
    bit         cap_en, ham_en, wrapped;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        for (int i = 0; i < 16; i++) if (gray_tab[i] == g) return 4'(i);
        return 4'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: compare outputs against the model, then advance the model on the edge
    task automatic tick();
        logic [3:0] cnt;
        logic       full, af;
        #1;
        cnt  = m_waddr - m_rbin;
        full = (cnt == 4'(DEPTH));
`ifdef FIFO_ALMOST_FULL_EN
        af = (cnt >= 4'(DEPTH - AFM));
`else
        af = 1'b0;
`endif
        check("wcount", 32'(wcount), 32'(cnt));
        check("wfull", 32'(wfull), 32'(full));
        check("waddr_g", 32'(waddr_g), 32'(m_gray));
        check("woverflow", 32'(woverflow), 32'(m_ovf));
        check("wafull", 32'(wafull), 32'(af));
        if (wrst && winc && !full) exp_q.push_back(m_waddr[2:0]);
        if (wrst && winc && !wfull) begin
            if (exp_q.size() == 0) check("accept_unexpected", 32'(1), 32'(0));
            else check("waddress", 32'(waddress), 32'(exp_q.pop_front()));
        end else if (exp_q.size() != 0) begin
            check("accept_missing", 32'(0), 32'(1));
            exp_q.delete();
        end
        if (cap_en && (gq.size() == 0 || gq[$] != waddr_g)) gq.push_back(waddr_g);
        if (ham_en) check("gray_hamming", 32'($countones(prev_g ^ waddr_g) <= 1), 32'(1));
        prev_g = waddr_g;
        @(posedge wclk);
        if (!wrst) begin
            m_waddr = 4'h0; m_rbin = 4'h0; m_gray = 4'h0; m_ovf = 1'b0;
        end else begin
            m_gray = gray_tab[m_waddr];
            if (winc && full) m_ovf = 1'b1;
            if (winc && !full) begin
                if (m_waddr == 4'hF) wrapped = 1'b1;
                m_waddr = m_waddr + 4'h1;
            end
            m_rbin = g2b(raddr_g);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cap_en = 0; ham_en = 0; wrapped = 0; prev_g = 4'h0; rd = 4'h0;
        wrst = 1'b0; winc = 1'b0; raddr_g = 4'h0;
        m_waddr = 4'h0; m_rbin = 4'h0; m_gray = 4'h0; m_ovf = 1'b0;

        // Reset held for two edges
        @(posedge wclk); #1;
        tick();
        wrst = 1'b1;
        check("rst_waddr_g", 32'(waddr_g), 32'(0));
        check("rst_wfull", 32'(wfull), 32'(0));
        check("rst_wcount", 32'(wcount), 32'(0));
        check("rst_woverflow", 32'(woverflow), 32'(0));

        // Fill with eight writes, then one rejected write
        cap_en = 1;
        winc = 1'b1;
        repeat (8) tick();
        check("full_after8", 32'(wfull), 32'(1));
        check("count_after8", 32'(wcount), 32'(8));
        tick();
        winc = 1'b0;
        check("ovf_set", 32'(woverflow), 32'(1));
        check("waddr_held", 32'(wcount), 32'(8));
        tick();
        tick();
        cap_en = 0;
        check("gray_seq_len", 32'(gq.size()), 32'(9));
        for (int i = 0; i < 9 && i < gq.size(); i++) check("gray_seq", 32'(gq[i]), 32'(gray_exp[i]));

        // Reader frees one slot; the same-cycle write is still rejected
        rd = 4'h1; raddr_g = gray_tab[rd]; winc = 1'b1;
        tick();
        check("full_same_cycle", 32'(wfull), 32'(0));
        check("count_freed", 32'(wcount), 32'(7));
        tick();
        check("refull", 32'(wfull), 32'(1));
        check("ovf_sticky", 32'(woverflow), 32'(1));

        // Free-running writer with a reader following, across the wrap
        ham_en = 1;
        for (int n = 0; n < 80; n++) begin
            winc = ($urandom_range(0, 3) != 0);
            if ((m_waddr - rd) != 4'h0 && $urandom_range(0, 3) != 0) rd = rd + 4'h1;
            raddr_g = gray_tab[rd];
            tick();
        end
        ham_en = 0;
        check("wrapped", 32'(wrapped), 32'(1));
        check("ovf_still", 32'(woverflow), 32'(1));

        // Reset mid-operation, then probe the almost-full threshold
        wrst = 1'b0; winc = 1'b0; rd = 4'h0; raddr_g = 4'h0;
        tick();
        wrst = 1'b1;
        check("rst2_ovf", 32'(woverflow), 32'(0));
        check("rst2_count", 32'(wcount), 32'(0));
        winc = 1'b1;
        repeat (5) tick();
        check("af_at5", 32'(wafull), 32'(0));
        tick();
        winc = 1'b0;
`ifdef FIFO_ALMOST_FULL_EN
        check("af_at6", 32'(wafull), 32'(1));
`else
        check("af_at6", 32'(wafull), 32'(0));
`endif
        check("count_at6", 32'(wcount), 32'(6));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
